multicycle_alu: RTL and testbench

Parametrised, clocked ALU for the processor datapath. It extends the 16-bit combinational ALU with configurable width, shifts, signed compare, XOR/NOR, and iterative unsigned multiply and divide. Operations are launched with a start/done handshake. Single-step ops complete in one cycle; MUL and DIV take WIDTH cycles. Results, the Zero flag and status flags are registered and held until the next completion.

---
 rtl/multicycle_alu_if.sv | 28 ++
 rtl/multicycle_alu.sv | 179 +++++++++++++++++
 tb/tb_multicycle_alu.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_alu_if.sv
// Launch/result bundle between a datapath controller (master) and multicycle_alu (slave).
// Handshake: start is taken on a rising clock edge only while busy is low; done pulses for one cycle when the result fields update.
interface multicycle_alu_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [3:0]       ALUControl;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] resultHi;
    logic             Zero;
    logic             overflow;
    logic             divByZero;
    logic             dbg_state;

    modport master (
        output start, ALUControl, input1, input2,
        input  busy, done, result, resultHi, Zero, overflow, divByZero, dbg_state
    );

    modport slave (
        input  start, ALUControl, input1, input2,
        output busy, done, result, resultHi, Zero, overflow, divByZero, dbg_state
    );
endinterface

// File: rtl/multicycle_alu.sv
// Clocked ALU: single-cycle logic/arith/shift/compare ops plus iterative unsigned MUL and restoring DIV.
// dbg_state exposes the IDLE/RUN state register.
module multicycle_alu #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic            clock,
    input  logic            reset_n,
    multicycle_alu_if.slave bus
);
    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [3:0] OP_AND  = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010, OP_EQ  = 4'b0011,
                           OP_XOR  = 4'b0100, OP_NOR = 4'b0101, OP_SUB = 4'b0110, OP_SLT = 4'b0111,
                           OP_SLTS = 4'b1000, OP_SLL = 4'b1001, OP_SRL = 4'b1010, OP_SRA = 4'b1011,
                           OP_MUL  = 4'b1100, OP_DIV = 4'b1101;
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    state_t           r_state, w_state_nxt;
    logic [SHW-1:0]   r_cnt, w_cnt_nxt;
    logic             r_is_div, w_is_div_nxt;
    logic [WIDTH-1:0] r_opb, w_opb_nxt, r_hi, w_hi_nxt, r_lo, w_lo_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt, r_result_hi, w_result_hi_nxt;
    logic             r_zero, w_zero_nxt, r_ovf, w_ovf_nxt, r_dbz, w_dbz_nxt;
    logic             r_done, w_done_nxt, r_busy, w_busy_nxt;

    logic [WIDTH-1:0] w_a, w_b, w_sum, w_diff, w_ss_result;
    logic [SHW-1:0]   w_shamt;
    logic [3:0]       w_op;
    logic             w_ss_ovf, w_launch_iter;
    logic [WIDTH:0]   w_mul_sum, w_div_shift;
    logic [WIDTH-1:0] w_div_sub, w_step_hi, w_step_lo;
    logic             w_div_ge;

    assign w_a           = bus.input1;
    assign w_b           = bus.input2;
    assign w_op          = bus.ALUControl;
    assign w_sum         = w_a + w_b;
    assign w_diff        = w_a - w_b;
    assign w_shamt       = w_b[SHW-1:0];
    assign w_launch_iter = (w_op == OP_MUL) || ((w_op == OP_DIV) && (w_b != '0));

    always_comb begin : single_step
        w_ss_result = '0;
        w_ss_ovf    = 1'b0;
        case (w_op)
            OP_AND:  w_ss_result = w_a & w_b;
            OP_OR:   w_ss_result = w_a | w_b;
            OP_ADD: begin
                w_ss_result = w_sum;
                w_ss_ovf    = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_ss_result = w_diff;
                w_ss_ovf    = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
            end
            OP_EQ:   w_ss_result = WIDTH'(w_a == w_b);
            OP_SLT:  w_ss_result = WIDTH'(w_a < w_b);
            OP_SLTS: w_ss_result = WIDTH'($signed(w_a) < $signed(w_b));
            OP_XOR:  w_ss_result = w_a ^ w_b;
            OP_NOR:  w_ss_result = ~(w_a | w_b);
            OP_SLL:  w_ss_result = w_a << w_shamt;
            OP_SRL:  w_ss_result = w_a >> w_shamt;
            OP_SRA:  w_ss_result = $signed(w_a) >>> w_shamt;
            OP_DIV:  w_ss_result = '1;  // only reached with a zero divisor
            default: w_ss_result = '0;
        endcase
    end

    // One iteration: r_hi holds partial product / remainder, r_lo holds multiplier / quotient bits.
    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_div_ge    = w_div_shift >= {1'b0, r_opb};
    assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_opb;

    always_comb begin : iter_step
        if (r_is_div) begin
            w_step_hi = w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0];
            w_step_lo = {r_lo[WIDTH-2:0], w_div_ge};
        end else begin
            w_step_hi = w_mul_sum[WIDTH:1];
            w_step_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    always_comb begin : fsm_next
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_is_div_nxt    = r_is_div;
        w_opb_nxt       = r_opb;
        w_hi_nxt        = r_hi;
        w_lo_nxt        = r_lo;
        w_result_nxt    = r_result;
        w_result_hi_nxt = r_result_hi;
        w_zero_nxt      = r_zero;
        w_ovf_nxt       = r_ovf;
        w_dbz_nxt       = r_dbz;
        w_done_nxt      = 1'b0;
        w_busy_nxt      = r_busy;
        case (r_state)
            S_IDLE: begin
                if (bus.start && w_launch_iter) begin
                    w_state_nxt  = S_RUN;
                    w_cnt_nxt    = CNT_LAST;
                    w_is_div_nxt = (w_op == OP_DIV);
                    w_opb_nxt    = w_b;
                    w_hi_nxt     = '0;
                    w_lo_nxt     = w_a;
                    w_busy_nxt   = 1'b1;
                end else if (bus.start) begin
                    w_result_nxt    = w_ss_result;
                    w_result_hi_nxt = (w_op == OP_DIV) ? w_a : '0;
                    w_zero_nxt      = (w_ss_result == '0);
                    w_ovf_nxt       = w_ss_ovf;
                    w_dbz_nxt       = (w_op == OP_DIV);
                    w_done_nxt      = 1'b1;
                end
            end
            S_RUN: begin
                w_hi_nxt = w_step_hi;
                w_lo_nxt = w_step_lo;
                if (r_cnt == '0) begin
                    w_result_nxt    = w_step_lo;
                    w_result_hi_nxt = w_step_hi;
                    w_zero_nxt      = (w_step_lo == '0);
                    w_ovf_nxt       = 1'b0;
                    w_dbz_nxt       = 1'b0;
                    w_done_nxt      = 1'b1;
                    w_busy_nxt      = 1'b0;
                    w_state_nxt     = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_is_div    <= 1'b0;
            r_opb       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_zero      <= 1'b1;
            r_ovf       <= 1'b0;
            r_dbz       <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_is_div    <= w_is_div_nxt;
            r_opb       <= w_opb_nxt;
            r_hi        <= w_hi_nxt;
            r_lo        <= w_lo_nxt;
            r_result    <= w_result_nxt;
            r_result_hi <= w_result_hi_nxt;
            r_zero      <= w_zero_nxt;
            r_ovf       <= w_ovf_nxt;
            r_dbz       <= w_dbz_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.result    = r_result;
    assign bus.resultHi  = r_result_hi;
    assign bus.Zero      = r_zero;
    assign bus.overflow  = r_ovf;
    assign bus.divByZero = r_dbz;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu at WIDTH=16 and WIDTH=32: drivers push expected results,
// one scoreboard process pops and compares on every done pulse.
module tb_multicycle_alu;
    logic clock = 1'b0;
    logic reset_n = 1'b1;

    always #5 clock = ~clock;

    multicycle_alu_if #(.WIDTH(16)) bus16 ();
    multicycle_alu_if #(.WIDTH(32)) bus32 ();

    multicycle_alu #(.WIDTH(16)) u_alu16 (.clock(clock), .reset_n(reset_n), .bus(bus16));
    multicycle_alu #(.WIDTH(32)) u_alu32 (.clock(clock), .reset_n(reset_n), .bus(bus32));

    // Expected entry: {result, resultHi, Zero, overflow, divByZero}
    logic [34:0] exp16_q[$];
    logic [66:0] exp32_q[$];
    int          lat16_q[$], lat32_q[$];
    int          t16_q[$], t32_q[$];
    string       nm16_q[$], nm32_q[$];

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int tmo_cnt = 0;
    bit all_done = 1'b0;
    bit rst_chk = 1'b0;
    bit bad16 = 1'b0;
    bit bad32 = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- driver tasks ----------------
    task automatic issue16(input string nm, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] er, input logic [15:0] eh,
                           input logic [2:0] ef, input int lat);
        exp16_q.push_back({er, eh, ef});
        lat16_q.push_back(lat);
        t16_q.push_back(cyc + 1);
        nm16_q.push_back(nm);
        bus16.ALUControl = op;
        bus16.input1     = a;
        bus16.input2     = b;
        bus16.start      = 1'b1;
        @(negedge clock);
        bus16.start      = 1'b0;
        bus16.ALUControl = 4'($urandom_range(0, 15));
        bus16.input1     = 16'($urandom_range(0, 65535));
        bus16.input2     = 16'($urandom_range(0, 65535));
    endtask

    task automatic issue32(input string nm, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] er, input logic [31:0] eh,
                           input logic [2:0] ef, input int lat);
        exp32_q.push_back({er, eh, ef});
        lat32_q.push_back(lat);
        t32_q.push_back(cyc + 1);
        nm32_q.push_back(nm);
        bus32.ALUControl = op;
        bus32.input1     = a;
        bus32.input2     = b;
        bus32.start      = 1'b1;
        @(negedge clock);
        bus32.start      = 1'b0;
        bus32.ALUControl = 4'($urandom_range(0, 15));
        bus32.input1     = $urandom();
        bus32.input2     = $urandom();
    endtask

    task automatic wait16();
        int n = 0;
        while (!bus16.done && n < 64) begin
            @(negedge clock);
            n++;
        end
        if (!bus16.done) tmo_cnt++;
    endtask

    task automatic wait32();
        int n = 0;
        while (!bus32.done && n < 96) begin
            @(negedge clock);
            n++;
        end
        if (!bus32.done) tmo_cnt++;
    endtask

    // ---------------- stimulus ----------------
    initial begin : driver
        bus16.start = 1'b0; bus16.ALUControl = 4'h0; bus16.input1 = '0; bus16.input2 = '0;
        bus32.start = 1'b0; bus32.ALUControl = 4'h0; bus32.input1 = '0; bus32.input2 = '0;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // single-step ops, flags are {Zero, overflow, divByZero}
        issue16("add_ovf",  4'b0010, 16'h7FFF, 16'h0001, 16'h8000, 16'h0, 3'b010, 0); wait16();
        issue16("sub_zero", 4'b0110, 16'h0005, 16'h0005, 16'h0000, 16'h0, 3'b100, 0); wait16();
        issue16("slt",      4'b0111, 16'hFFFF, 16'h0001, 16'h0000, 16'h0, 3'b100, 0); wait16();
        issue16("slts",     4'b1000, 16'hFFFF, 16'h0001, 16'h0001, 16'h0, 3'b000, 0); wait16();
        issue16("sra",      4'b1011, 16'h8000, 16'h0013, 16'hF000, 16'h0, 3'b000, 0); wait16();
        issue16("sll",      4'b1001, 16'h0001, 16'h0004, 16'h0010, 16'h0, 3'b000, 0); wait16();
        issue16("srl",      4'b1010, 16'h8000, 16'h000F, 16'h0001, 16'h0, 3'b000, 0); wait16();
        issue16("and",      4'b0000, 16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0, 3'b000, 0); wait16();
        issue16("or",       4'b0001, 16'hF000, 16'h000F, 16'hF00F, 16'h0, 3'b000, 0); wait16();
        issue16("xor",      4'b0100, 16'hFFFF, 16'h00FF, 16'hFF00, 16'h0, 3'b000, 0); wait16();
        issue16("nor",      4'b0101, 16'h0000, 16'h0000, 16'hFFFF, 16'h0, 3'b000, 0); wait16();
        issue16("eq",       4'b0011, 16'h1234, 16'h1234, 16'h0001, 16'h0, 3'b000, 0); wait16();
        issue16("sub_ovf",  4'b0110, 16'h8000, 16'h0001, 16'h7FFF, 16'h0, 3'b010, 0); wait16();
        issue16("add_wrap", 4'b0010, 16'hFFFF, 16'h0001, 16'h0000, 16'h0, 3'b100, 0); wait16();
        issue16("op_1110",  4'b1110, 16'h1234, 16'h5678, 16'h0000, 16'h0, 3'b100, 0); wait16();
        issue16("div_zero", 4'b1101, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 3'b001, 0); wait16();

        // MUL with an ignored start mid-run
        issue16("mul_max",  4'b1100, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 3'b000, 16);
        repeat (4) @(negedge clock);
        bus16.ALUControl = 4'b0000; bus16.input1 = 16'hFFFF; bus16.input2 = 16'hFFFF; bus16.start = 1'b1;
        @(negedge clock);
        bus16.start = 1'b0;
        wait16();
        issue16("div",      4'b1101, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 3'b000, 16); wait16();

        // back-to-back: AND in the MUL done cycle, then OR
        issue16("mul_b2b",  4'b1100, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 3'b000, 16); wait16();
        issue16("and_b2b",  4'b0000, 16'h00FF, 16'h0F0F, 16'h000F, 16'h0, 3'b000, 0);
        issue16("or_b2b",   4'b0001, 16'h00F0, 16'h000F, 16'h00FF, 16'h0, 3'b000, 0); wait16();

        issue32("mul32",    4'b1100, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h00000001, 3'b000, 32); wait32();
        issue32("and32",    4'b0000, 32'hDEADBEEF, 32'hFFFF0000, 32'hDEAD0000, 32'h0, 3'b000, 0);
        issue32("or32",     4'b0001, 32'h12340000, 32'h00005678, 32'h12345678, 32'h0, 3'b000, 0); wait32();
        issue32("div32",    4'b1101, 32'h000F4240, 32'h00000007, 32'h00022E09, 32'h00000001, 3'b000, 32); wait32();
        issue32("add32_ovf", 4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 3'b010, 0); wait32();

        // reset mid-MUL: the aborted op must never complete
        issue16("mul_abort", 4'b1100, 16'h1234, 16'h0010, 16'h2340, 16'h0001, 3'b000, 16);
        repeat (4) @(negedge clock);
        @(posedge clock);
        #2 reset_n = 1'b0;
        exp16_q.delete(); lat16_q.delete(); t16_q.delete(); nm16_q.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (25) @(negedge clock);

        all_done = 1'b1;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    task automatic cmp(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic check16();
        if (exp16_q.size() > 0 && lat16_q[0] > 0 && cyc >= t16_q[0] &&
            cyc < t16_q[0] + lat16_q[0] && !bus16.busy) bad16 = 1'b1;
        if (bus16.done) begin
            if (exp16_q.size() == 0) begin
                cmp("w16 unexpected done", bus16.done, 1'b0);
            end else begin
                cmp(nm16_q[0], {bus16.result, bus16.resultHi, bus16.Zero, bus16.overflow, bus16.divByZero},
                    exp16_q[0]);
                cmp({nm16_q[0], " latency"}, cyc - t16_q[0], lat16_q[0]);
                cmp({nm16_q[0], " busy"}, {bus16.busy, bad16}, 2'b00);
                bad16 = 1'b0;
                void'(exp16_q.pop_front()); void'(lat16_q.pop_front());
                void'(t16_q.pop_front());   void'(nm16_q.pop_front());
            end
        end
    endtask

    task automatic check32();
        if (exp32_q.size() > 0 && lat32_q[0] > 0 && cyc >= t32_q[0] &&
            cyc < t32_q[0] + lat32_q[0] && !bus32.busy) bad32 = 1'b1;
        if (bus32.done) begin
            if (exp32_q.size() == 0) begin
                cmp("w32 unexpected done", bus32.done, 1'b0);
            end else begin
                cmp(nm32_q[0], {bus32.result, bus32.resultHi, bus32.Zero, bus32.overflow, bus32.divByZero},
                    exp32_q[0]);
                cmp({nm32_q[0], " latency"}, cyc - t32_q[0], lat32_q[0]);
                cmp({nm32_q[0], " busy"}, {bus32.busy, bad32}, 2'b00);
                bad32 = 1'b0;
                void'(exp32_q.pop_front()); void'(lat32_q.pop_front());
                void'(t32_q.pop_front());   void'(nm32_q.pop_front());
            end
        end
    endtask

    initial begin : scoreboard
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                if (!rst_chk) begin
                    rst_chk = 1'b1;
                    cmp("w16 reset state", {bus16.busy, bus16.done, bus16.dbg_state, bus16.result, bus16.resultHi,
                        bus16.Zero, bus16.overflow, bus16.divByZero}, {3'b000, 32'h0, 3'b100});
                    cmp("w32 reset state", {bus32.busy, bus32.done, bus32.dbg_state, bus32.result, bus32.resultHi,
                        bus32.Zero, bus32.overflow, bus32.divByZero}, {3'b000, 64'h0, 3'b100});
                end
            end else begin
                rst_chk = 1'b0;
                check16();
                check32();
                if (all_done) begin
                    cmp("w16 outstanding", exp16_q.size(), 0);
                    cmp("w32 outstanding", exp32_q.size(), 0);
                    cmp("done timeouts", tmo_cnt, 0);
                    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                    $finish;
                end
            end
        end
    end
endmodule
